// File: rtl/arp_pkg.sv
// ============================================================================
// arp_pkg : shared types and constants for the ARP IP->MAC cache
// Rev 1.0 : initial release
// ============================================================================
`default_nettype none

package arp_pkg;

  localparam logic ARP_OP_REQ   = 1'b0;
  localparam logic ARP_OP_REPLY = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_SCAN     = 3'd1,
    ST_REQ      = 3'd2,
    ST_WAIT_TX  = 3'd3,
    ST_WAIT_RSP = 3'd4,
    ST_DONE     = 3'd5
  } lkup_state_e;

  typedef struct packed {
    logic        valid;
    logic [31:0] ip;
    logic [47:0] mac;
  } arp_entry_t;

  // Unspecified and limited-broadcast addresses can never be resolved.
  function automatic logic ip_is_special(input logic [31:0] ip);
    return (ip == 32'h0000_0000) || (ip == 32'hFFFF_FFFF);
  endfunction

endpackage

`default_nettype wire

// File: rtl/arp_age_tick.sv
// ============================================================================
// arp_age_tick : free-running prescaler, one-cycle tick every AGE_CYCLES clocks
// Rev 1.0 : initial release (used only when ARP_CACHE_AGING_EN is defined)
// ============================================================================
`default_nettype none

module arp_age_tick #(
  parameter int unsigned AGE_CYCLES = 125_000_000
) (
  input  logic clk,
  input  logic rst_n,
  output logic tick_o
);

  localparam int unsigned CW = (AGE_CYCLES > 1) ? $clog2(AGE_CYCLES) : 1;

  logic [CW-1:0] cnt_q;
  logic          tick_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      tick_q <= 1'b0;
    end else if (cnt_q == CW'(AGE_CYCLES - 1)) begin
      cnt_q  <= '0;
      tick_q <= 1'b1;
    end else begin
      cnt_q  <= cnt_q + CW'(1);
      tick_q <= 1'b0;
    end
  end

  assign tick_o = tick_q;

endmodule

`default_nettype wire

// File: rtl/arp_cache.sv
// ============================================================================
// arp_cache : IP->MAC table learned from received ARP, with miss resolution
// Rev 1.0 : initial release; entry aging enabled by macro ARP_CACHE_AGING_EN
// ============================================================================
`default_nettype none

module arp_cache
  import arp_pkg::*;
#(
  parameter int unsigned DEPTH        = 8,
  parameter int unsigned RETRY_CYCLES = 125_000_000,
  parameter int unsigned MAX_RETRY    = 3,
  parameter int unsigned AGE_CYCLES   = 125_000_000,
  parameter int unsigned AGE_LIMIT    = 60
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        arp_rx_done,
  input  logic        arp_rx_type,
  input  logic [47:0] src_mac,
  input  logic [31:0] src_ip,
  input  logic        lkup_req,
  input  logic [31:0] lkup_ip,
  output logic        lkup_ack,
  output logic        lkup_hit,
  output logic [47:0] lkup_mac,
  output logic        arp_tx_en,
  output logic        arp_tx_type,
  output logic [31:0] req_ip,
  input  logic        tx_done
);

  localparam int unsigned IW = $clog2(DEPTH);
  localparam int unsigned RW = $clog2(MAX_RETRY + 1);
  localparam int unsigned TW = (RETRY_CYCLES > 1) ? $clog2(RETRY_CYCLES) : 1;

  if (DEPTH < 2 || DEPTH > 32 || (DEPTH & (DEPTH - 1)) != 0 || RETRY_CYCLES == 0 ||
      MAX_RETRY == 0 || AGE_CYCLES == 0 || AGE_LIMIT == 0) begin : g_param_check
    $error("arp_cache: unsupported parameter set");
  end

  arp_entry_t  tbl_q [DEPTH];
  logic [IW-1:0] rr_ptr_q;

  lkup_state_e   state_q;
  logic [IW-1:0] idx_q;
  logic [RW-1:0] retry_q;
  logic [TW-1:0] timer_q;
  logic [31:0]   ip_q;
  logic          res_hit_q;
  logic [47:0]   res_mac_q;
  logic          lkup_ack_q;
  logic          lkup_hit_q;
  logic [47:0]   lkup_mac_q;
  logic          arp_tx_en_q;
  logic [31:0]   req_ip_q;

  logic          w_learn;
  logic          w_match_found;
  logic          w_free_found;
  logic [IW-1:0] w_match_idx;
  logic [IW-1:0] w_free_idx;
  logic [IW-1:0] w_wr_idx;
  logic          w_snoop;
  logic          w_scan_hit;

  // Requests and replies both carry a trustworthy sender pair.
  assign w_learn = arp_rx_done && (arp_rx_type == ARP_OP_REQ || arp_rx_type == ARP_OP_REPLY)
                   && (src_ip != 32'h0);

  always_comb begin
    w_match_found = 1'b0;
    w_free_found  = 1'b0;
    w_match_idx   = '0;
    w_free_idx    = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (tbl_q[i].valid && tbl_q[i].ip == src_ip) begin
        w_match_found = 1'b1;
        w_match_idx   = IW'(i);
      end
      if (!tbl_q[i].valid) begin
        w_free_found = 1'b1;
        w_free_idx   = IW'(i);
      end
    end
    w_wr_idx = w_match_found ? w_match_idx : (w_free_found ? w_free_idx : rr_ptr_q);
  end

  assign w_snoop    = arp_rx_done && (src_ip == ip_q);
  assign w_scan_hit = (state_q == ST_SCAN) && tbl_q[idx_q].valid && (tbl_q[idx_q].ip == ip_q);

`ifdef ARP_CACHE_AGING_EN
  localparam int unsigned AW = $clog2(AGE_LIMIT + 1);

  logic          w_age_tick;
  logic [AW-1:0] age_q [DEPTH];

  arp_age_tick #(.AGE_CYCLES(AGE_CYCLES)) u_age_tick (
    .clk    (clk),
    .rst_n  (rst_n),
    .tick_o (w_age_tick)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) age_q[i] <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if ((w_learn && w_wr_idx == IW'(i)) || (w_scan_hit && idx_q == IW'(i)))
          age_q[i] <= '0;
        else if (w_age_tick && tbl_q[i].valid)
          age_q[i] <= age_q[i] + AW'(1);
      end
    end
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) tbl_q[i] <= '0;
      rr_ptr_q <= '0;
    end else begin
`ifdef ARP_CACHE_AGING_EN
      for (int i = 0; i < DEPTH; i++) begin
        if (w_age_tick && tbl_q[i].valid && age_q[i] == AW'(AGE_LIMIT - 1))
          tbl_q[i].valid <= 1'b0;
      end
`endif
      // Issued last so a same-cycle learn overrides expiry of its own entry.
      if (w_learn) begin
        tbl_q[w_wr_idx] <= '{valid: 1'b1, ip: src_ip, mac: src_mac};
        if (!w_match_found && !w_free_found) rr_ptr_q <= rr_ptr_q + IW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      idx_q       <= '0;
      retry_q     <= '0;
      timer_q     <= '0;
      ip_q        <= '0;
      res_hit_q   <= 1'b0;
      res_mac_q   <= '0;
      lkup_ack_q  <= 1'b0;
      lkup_hit_q  <= 1'b0;
      lkup_mac_q  <= '0;
      arp_tx_en_q <= 1'b0;
      req_ip_q    <= '0;
    end else begin
      lkup_ack_q  <= 1'b0;
      arp_tx_en_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (lkup_req) begin
            ip_q    <= lkup_ip;
            idx_q   <= '0;
            retry_q <= '0;
            if (ip_is_special(lkup_ip)) begin
              res_hit_q <= 1'b0;
              res_mac_q <= '0;
              state_q   <= ST_DONE;
            end else begin
              state_q <= ST_SCAN;
            end
          end
        end
        ST_SCAN: begin
          if (w_snoop) begin
            res_hit_q <= 1'b1;
            res_mac_q <= src_mac;
            state_q   <= ST_DONE;
          end else if (w_scan_hit) begin
            res_hit_q <= 1'b1;
            res_mac_q <= tbl_q[idx_q].mac;
            state_q   <= ST_DONE;
          end else if (idx_q == IW'(DEPTH - 1)) begin
            state_q <= ST_REQ;
          end else begin
            idx_q <= idx_q + IW'(1);
          end
        end
        ST_REQ: begin
          arp_tx_en_q <= 1'b1;
          req_ip_q    <= ip_q;
          retry_q     <= retry_q + RW'(1);
          state_q     <= ST_WAIT_TX;
        end
        ST_WAIT_TX: begin
          if (w_snoop) begin
            res_hit_q <= 1'b1;
            res_mac_q <= src_mac;
            state_q   <= ST_DONE;
          end else if (tx_done) begin
            timer_q <= TW'(RETRY_CYCLES - 1);
            state_q <= ST_WAIT_RSP;
          end
        end
        ST_WAIT_RSP: begin
          if (w_snoop) begin
            res_hit_q <= 1'b1;
            res_mac_q <= src_mac;
            state_q   <= ST_DONE;
          end else if (timer_q == '0) begin
            if (retry_q < RW'(MAX_RETRY)) begin
              state_q <= ST_REQ;
            end else begin
              res_hit_q <= 1'b0;
              res_mac_q <= '0;
              state_q   <= ST_DONE;
            end
          end else begin
            timer_q <= timer_q - TW'(1);
          end
        end
        ST_DONE: begin
          lkup_ack_q <= 1'b1;
          lkup_hit_q <= res_hit_q;
          lkup_mac_q <= res_hit_q ? res_mac_q : 48'h0;
          state_q    <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign lkup_ack    = lkup_ack_q;
  assign lkup_hit    = lkup_hit_q;
  assign lkup_mac    = lkup_mac_q;
  assign arp_tx_en   = arp_tx_en_q;
  assign arp_tx_type = ARP_OP_REQ;
  assign req_ip      = req_ip_q;

endmodule

`default_nettype wire
